// File: rtl/enoc_node_interface.sv
// -----------------------------------------------------------------------------
// enoc_node_interface
//
// Network interface between one traffic generator/sink and local router port 0.
//
// Injection: each generator request is stamped with this node's id (source)
// and the current cycle count (timestamp), pushed into a small FIFO and offered
// to the router with a valid/enable handshake.
// Ejection: packets offered by the router are accepted while o_en is high.
// Every accepted packet updates the delivery count, the latency sum and the
// latency maximum. A packet whose dest field is not this node sets a sticky
// misroute flag.
//
// Packet layout (MSB..LSB): {dest, source, data, timestamp}
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   i_gen_dest/data/val   generator request
//   o_gen_ready           FIFO can accept a request this cycle
//   o_data, o_data_val    FIFO head offered to the router
//   i_en                  router accepts the offered head at this edge
//   i_data, i_data_val    packet offered by the router
//   o_en                  this node accepts router packets (registered)
//   i_sink_hold           sink backpressure request
//   o_tx_count            packets accepted by the network (wraps)
//   o_rx_count            packets ejected (wraps)
//   o_lat_sum             saturating sum of ejection latencies
//   o_lat_max             largest single ejection latency
//   o_misroute            sticky: some ejected packet had dest != NODE_ID
// -----------------------------------------------------------------------------
module enoc_node_interface #(
    parameter int NODE_ID    = 0,
    parameter int NODES      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 16,
    localparam int DEST_W    = (NODES > 1) ? $clog2(NODES) : 1,
    localparam int PKT_W     = 2 * DEST_W + DATA_WIDTH + TS_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DEST_W-1:0]     i_gen_dest,
    input  logic [DATA_WIDTH-1:0] i_gen_data,
    input  logic                  i_gen_val,
    output logic                  o_gen_ready,
    output logic [PKT_W-1:0]      o_data,
    output logic                  o_data_val,
    input  logic                  i_en,
    input  logic [PKT_W-1:0]      i_data,
    input  logic                  i_data_val,
    output logic                  o_en,
    input  logic                  i_sink_hold,
    output logic [CNT_WIDTH-1:0]  o_tx_count,
    output logic [CNT_WIDTH-1:0]  o_rx_count,
    output logic [CNT_WIDTH-1:0]  o_lat_sum,
    output logic [TS_WIDTH-1:0]   o_lat_max,
    output logic                  o_misroute
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int TS_LSB   = 0;
    localparam int DATA_LSB = TS_LSB + TS_WIDTH;
    localparam int SRC_LSB  = DATA_LSB + DATA_WIDTH;
    localparam int DEST_LSB = SRC_LSB + DEST_W;

    localparam logic [DEST_W-1:0] MY_ID    = DEST_W'(NODE_ID);
    localparam logic [AW:0]       CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    // ---------------------------------------------------------------- state
    logic [TS_WIDTH-1:0]  now_q;
    logic [PKT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    logic [AW:0]          count_d;
    logic                 ready_q;
    logic                 valid_q;
    logic                 en_q;
    logic [CNT_WIDTH-1:0] tx_count_q;
    logic [CNT_WIDTH-1:0] rx_count_q;
    logic [CNT_WIDTH-1:0] lat_sum_q;
    logic [TS_WIDTH-1:0]  lat_max_q;
    logic                 misroute_q;

    // ---------------------------------------------------------------- comb
    logic                 push_s;
    logic                 pop_s;
    logic                 eject_s;
    logic [PKT_W-1:0]     pkt_in_s;
    logic [TS_WIDTH-1:0]  lat_s;
    logic [CNT_WIDTH:0]   sum_ext_s;
    logic                 wrong_dest_s;
    logic                 unused_fields_s;

    // Enqueue uses the registered ready, so a pop in the same cycle never
    // frees a slot for that cycle's push.
    assign push_s   = i_gen_val && ready_q;
    assign pop_s    = valid_q && i_en;
    assign eject_s  = i_data_val && en_q;
    assign pkt_in_s = {i_gen_dest, MY_ID, i_gen_data, now_q};

    // Latency is taken modulo the timestamp width, so a wrapped counter
    // still yields the true distance.
    assign lat_s        = now_q - i_data[TS_LSB +: TS_WIDTH];
    assign sum_ext_s    = {1'b0, lat_sum_q} + (CNT_WIDTH + 1)'(lat_s);
    assign wrong_dest_s = (i_data[DEST_LSB +: DEST_W] != MY_ID);

    // Source and payload of ejected packets are not inspected here.
    assign unused_fields_s = ^{i_data[SRC_LSB +: DEST_W], i_data[DATA_LSB +: DATA_WIDTH]};

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Free-running cycle counter used for timestamps and latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            now_q <= '0;
        end else begin
            now_q <= now_q + TS_WIDTH'(1);
        end
    end

    // Injection FIFO storage, pointers and registered ready/valid flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= pkt_in_s;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != CNT_FULL);
            valid_q <= (count_d != '0);
        end
    end

    // Count of packets taken by the network.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_count_q <= '0;
        end else if (pop_s) begin
            tx_count_q <= tx_count_q + CNT_WIDTH'(1);
        end
    end

    // Ejection enable: one-cycle-late image of the sink's hold request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= !i_sink_hold;
        end
    end

    // Ejection statistics and sticky misroute flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_count_q <= '0;
            lat_sum_q  <= '0;
            lat_max_q  <= '0;
            misroute_q <= 1'b0;
        end else if (eject_s) begin
            rx_count_q <= rx_count_q + CNT_WIDTH'(1);
            lat_sum_q  <= sum_ext_s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum_ext_s[CNT_WIDTH-1:0];
            if (lat_s > lat_max_q) begin
                lat_max_q <= lat_s;
            end
            if (wrong_dest_s) begin
                misroute_q <= 1'b1;
            end
        end
    end

    assign o_gen_ready = ready_q;
    assign o_data_val  = valid_q;
    assign o_data      = mem_q[rd_ptr_q];
    assign o_en        = en_q;
    assign o_tx_count  = tx_count_q;
    assign o_rx_count  = rx_count_q;
    assign o_lat_sum   = lat_sum_q;
    assign o_lat_max   = lat_max_q;
    assign o_misroute  = misroute_q;

endmodule

// File: doc/enoc_node_interface.md
# enoc_node_interface

Per-node network interface that sits between one traffic generator/sink and its local router port (port 0) in the ENoC network. On injection it stamps source and timestamp on each generator packet, buffers it in a FIFO, and drives it into the network with the valid/enable protocol. On ejection it consumes packets from the network, checks routing, and accumulates delivery and latency statistics.

## Interface
Parameters:
- NODE_ID, 0: this node's index, written into every packet's source field and checked against every received packet's dest field.
- NODES, `NODES: total node count; dest and source are log2(NODES) bits wide.
- FIFO_DEPTH, `INPUT_QUEUE_DEPTH: injection FIFO entries, a power of 2 and at least 2.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_gen_dest  in  log2(NODES)  generator destination.
- i_gen_data  in  packet_t.data width  generator payload.
- i_gen_val  in  1  generator request valid.
- o_gen_ready  out  1  FIFO can accept a packet.
- o_data  out  packet_t  packet to the router's local input.
- o_data_val  out  1  o_data valid.
- i_en  in  1  router enables this node to send.
- i_data  in  packet_t  packet from the router's local output.
- i_data_val  in  1  i_data valid.
- o_en  out  1  enables the router to deliver to this node.
- i_sink_hold  in  1  sink backpressure request.
- o_tx_count  out  CNT_WIDTH  packets accepted by the network.
- o_rx_count  out  CNT_WIDTH  packets ejected.
- o_lat_sum  out  CNT_WIDTH  sum of ejected latencies.
- o_lat_max  out  packet_t.timestamp width  largest single latency.
- o_misroute  out  1  sticky flag: a received packet had dest != NODE_ID.

## Operation
- packet_t carries the fields dest, source, data and timestamp. This block writes all four on injection.
- Cycle counter `now`:
  - Width equals the timestamp field width.
  - Resets to 0, increments every cycle and wraps modulo 2^width.
- Enqueue:
  - Occurs at an edge where i_gen_val && o_gen_ready.
  - Writes {dest=i_gen_dest, source=NODE_ID, data=i_gen_data, timestamp=now} at that edge.
  - o_gen_ready = !full. A dequeue in the same cycle does not free the slot for that cycle's enqueue.
- Injection handshake:
  - o_data_val = !empty. o_data = FIFO head, registered storage.
  - Transfer occurs at an edge where o_data_val && i_en. The head pops and o_tx_count increments.
  - o_data_val does not depend on i_en.
  - o_data stays stable while o_data_val=1 and no transfer has occurred.
- Simultaneous enqueue and dequeue (not full): occupancy is unchanged and both take effect.
- Ejection:
  - o_en is a register: o_en <= !i_sink_hold.
  - A packet is ejected at an edge where i_data_val && o_en. At that edge:
    - o_rx_count increments.
    - lat = (now - i_data.timestamp) mod 2^width.
    - o_lat_sum += lat, saturating at all-ones.
    - o_lat_max = max(o_lat_max, lat).
    - If i_data.dest != NODE_ID, o_misroute sets and stays set until reset. The packet is still counted.
  - When i_data_val=1 and o_en=0, nothing is counted.
- o_tx_count and o_rx_count wrap modulo 2^CNT_WIDTH.
- Injection and ejection are independent. Both may transfer in the same cycle.

## Timing
- Reset values: o_gen_ready=0 while reset_n=0, and 1 from the first cycle after reset release. All other outputs are 0: o_data_val, o_data, o_en, all counters, o_lat_max, o_misroute, `now`, FIFO pointers.
- Reset asserted mid-operation clears the FIFO immediately, asynchronously. Queued packets are discarded and not counted.
- Enqueue-to-valid latency: a packet enqueued into an empty FIFO at edge k has o_data_val=1 from k to k+1.
- Throughput:
  - One injection per cycle while i_en=1 and the FIFO is non-empty.
  - One ejection per cycle while o_en=1.
- Backpressure: o_en responds to i_sink_hold one cycle late. i_sink_hold asserted at edge k gives o_en=0 from k.
- Full: after FIFO_DEPTH enqueues with i_en=0, o_gen_ready=0. It returns to 1 in the cycle after the first pop.

## Test plan
- Loopback, NODE_ID=3, o_data→i_data, i_en=1, i_sink_hold=0.
  - Stimulus: one packet dest=3 enqueued when now=5.
  - Required: ejected at now=6, lat=1, o_rx_count=1, o_tx_count=1, o_lat_sum=1, o_misroute=0.
- Full/backpressure, FIFO_DEPTH=4, i_en=0.
  - Stimulus: 6 requests with i_gen_val held at 1.
  - Required: exactly 4 accepted, then o_gen_ready=0 and o_data_val=1 with head data unchanged. After raising i_en, the packets emerge in FIFO order and o_tx_count=4.
- Latency wrap:
  - Stimulus: eject a packet with timestamp=0xFFFE when now=0x0003 (16-bit timestamp).
  - Required: lat=5, o_lat_max=5.
- Misroute, NODE_ID=2:
  - Stimulus: inject i_data dest=1 with o_en=1.
  - Required: o_misroute=1 and remains 1 after 10 idle cycles; o_rx_count=1.
- Sink hold:
  - Stimulus: i_sink_hold=1 for 3 cycles with i_data_val=1 throughout.
  - Required: no count during the held cycles. Counting resumes one cycle after hold release.
- Reset mid-operation:
  - Stimulus: 3 packets queued, then assert reset_n=0 between edges.
  - Required: o_data_val=0 immediately, all counters 0. After release, the FIFO is empty and o_gen_ready=1.
